// File: rtl/demux_stream_param_module.sv
// rtl/demux_stream_param_module.sv - registered 1-to-N stream demultiplexer with per-channel holding registers
// Out-of-range selects are accepted and discarded, flagged by a sticky err and a saturating drop count.
module demux_stream_param_module #(
  parameter int WIDTH = 2,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT),
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic                   err,
  output logic [CNT_W-1:0]       drop_cnt
);

  // One extra bit so N_OUT itself is representable when it equals 2^SEL_W.
  localparam logic [SEL_W:0] N_OUT_W = (SEL_W + 1)'(N_OUT);

  logic [N_OUT-1:0][WIDTH-1:0] data_q, data_d;
  logic [N_OUT-1:0]            valid_q, valid_d;
  logic                        err_q, err_d;
  logic [CNT_W-1:0]            drop_q, drop_d;

  logic [N_OUT-1:0] sel_hit;
  logic             in_range;
  logic             accept;

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
  end

  assign in_range = ({1'b0, in_sel} < N_OUT_W);
  // A FULL channel can take a new word only when its consumer drains it in the same cycle.
  assign in_ready = !in_range || (|(sel_hit & (~valid_q | out_ready)));
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    err_d   = err_q;
    drop_d  = drop_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (accept && sel_hit[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
    if (accept && !in_range) begin
      err_d = 1'b1;
      if (drop_q != {CNT_W{1'b1}}) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign err       = err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_stream_param_module.sv
// tb/tb_demux_stream_param_module.sv - directed bench for demux_stream_param_module
// Three instances cover the power-of-two, out-of-range and saturation configurations.
module tb_demux_stream_param_module;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance a: WIDTH=2, N_OUT=4, CNT_W=8
  logic [1:0] a_in_data = '0;
  logic [1:0] a_in_sel = '0;
  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [7:0] a_out_data;
  logic [3:0] a_out_valid;
  logic [3:0] a_out_ready = '0;
  logic       a_err;
  logic [7:0] a_drop;

  // Instance b: WIDTH=2, N_OUT=3, CNT_W=8
  logic [1:0] b_in_data = '0;
  logic [1:0] b_in_sel = '0;
  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [5:0] b_out_data;
  logic [2:0] b_out_valid;
  logic [2:0] b_out_ready = '0;
  logic       b_err;
  logic [7:0] b_drop;

  // Instance c: WIDTH=2, N_OUT=3, CNT_W=2
  logic [1:0] c_in_data = '0;
  logic [1:0] c_in_sel = '0;
  logic       c_in_valid = 1'b0;
  logic       c_in_ready;
  logic [5:0] c_out_data;
  logic [2:0] c_out_valid;
  logic [2:0] c_out_ready = '0;
  logic       c_err;
  logic [1:0] c_drop;

  demux_stream_param_module #(.WIDTH(2), .N_OUT(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .err(a_err), .drop_cnt(a_drop)
  );

  demux_stream_param_module #(.WIDTH(2), .N_OUT(3), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .err(b_err), .drop_cnt(b_drop)
  );

  demux_stream_param_module #(.WIDTH(2), .N_OUT(3), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_sel(c_in_sel), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .err(c_err), .drop_cnt(c_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b want 0000", a_out_valid); end
    n_cmp++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", a_out_data); end
    n_cmp++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", b_err); end
    n_cmp++; if (b_drop !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", b_drop); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
  endtask

  task automatic test_route();
    a_out_ready = 4'b0000;
    a_in_sel = 2'd2; a_in_data = 2'b11; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 4'b0100) begin n_fail++; $display("FAIL route_valid got %b want 0100", a_out_valid); end
    n_cmp++; if (a_out_data[5:4] !== 2'b11) begin n_fail++; $display("FAIL route_lane2 got %b want 11", a_out_data[5:4]); end
    a_in_sel = 2'd2; #1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL route_ready_sel2 got %b want 0", a_in_ready); end
    a_in_sel = 2'd1; #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL route_ready_sel1 got %b want 1", a_in_ready); end
  endtask

  task automatic test_stall_pass_through();
    a_in_sel = 2'd2; a_in_data = 2'b01; a_in_valid = 1'b1; a_out_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 0", i, a_in_ready); end
      tick();
      n_cmp++; if (a_out_data[5:4] !== 2'b11) begin n_fail++; $display("FAIL stall_lane2[%0d] got %b want 11", i, a_out_data[5:4]); end
    end
    a_out_ready = 4'b0100; #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL pass_ready got %b want 1", a_in_ready); end
    tick();
    a_in_valid = 1'b0; a_out_ready = 4'b0000;
    n_cmp++; if (a_out_data[5:4] !== 2'b01) begin n_fail++; $display("FAIL pass_lane2 got %b want 01", a_out_data[5:4]); end
    n_cmp++; if (a_out_valid !== 4'b0100) begin n_fail++; $display("FAIL pass_valid got %b want 0100", a_out_valid); end
  endtask

  task automatic test_parallel_fill();
    a_out_ready = 4'b1111;
    tick();
    a_out_ready = 4'b0000;
    n_cmp++; if (a_out_valid !== 4'b0000) begin n_fail++; $display("FAIL fill_predrain got %b want 0000", a_out_valid); end
    for (int i = 0; i < 4; i++) begin
      a_in_sel = 2'(i); a_in_data = 2'(i); a_in_valid = 1'b1; #1;
      n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got %b want 1", i, a_in_ready); end
      tick();
    end
    a_in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 4'b1111) begin n_fail++; $display("FAIL fill_valid got %b want 1111", a_out_valid); end
    n_cmp++; if (a_out_data !== 8'b11_10_01_00) begin n_fail++; $display("FAIL fill_data got %b want 11100100", a_out_data); end
    a_out_ready = 4'b1111;
    tick();
    a_out_ready = 4'b0000;
    n_cmp++; if (a_out_valid !== 4'b0000) begin n_fail++; $display("FAIL drain_valid got %b want 0000", a_out_valid); end
    n_cmp++; if (a_out_data !== 8'b11_10_01_00) begin n_fail++; $display("FAIL drain_hold got %b want 11100100", a_out_data); end
  endtask

  task automatic test_out_of_range();
    b_out_ready = 3'b000;
    b_in_sel = 2'd0; b_in_data = 2'b10; b_in_valid = 1'b1;
    tick();
    b_in_sel = 2'd3; b_in_data = 2'b01; #1;
    n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL oor_ready got %b want 1", b_in_ready); end
    tick();
    n_cmp++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL oor_err_first got %b want 1", b_err); end
    n_cmp++; if (b_drop !== 8'd1) begin n_fail++; $display("FAIL oor_drop_first got %0d want 1", b_drop); end
    tick();
    b_in_valid = 1'b0;
    n_cmp++; if (b_drop !== 8'd2) begin n_fail++; $display("FAIL oor_drop got %0d want 2", b_drop); end
    n_cmp++; if (b_out_valid !== 3'b001) begin n_fail++; $display("FAIL oor_valid got %b want 001", b_out_valid); end
    n_cmp++; if (b_out_data !== 6'b00_00_10) begin n_fail++; $display("FAIL oor_data got %b want 000010", b_out_data); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_drop;
    c_in_sel = 2'd3; c_in_data = 2'b11; c_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_drop = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_cmp++; if (c_drop !== exp_drop) begin n_fail++; $display("FAIL sat_drop[%0d] got %0d want %0d", i, c_drop, exp_drop); end
    end
    c_in_valid = 1'b0;
    n_cmp++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL sat_err got %b want 1", c_err); end
    n_cmp++; if (c_out_valid !== 3'b000) begin n_fail++; $display("FAIL sat_valid got %b want 000", c_out_valid); end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 4'b0000;
    a_in_sel = 2'd0; a_in_data = 2'b01; a_in_valid = 1'b1;
    tick();
    a_in_sel = 2'd3; a_in_data = 2'b10;
    tick();
    a_in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 4'b1001) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1001", a_out_valid); end
    a_in_sel = 2'd1; a_in_data = 2'b11; a_in_valid = 1'b1;
    b_in_sel = 2'd1; b_in_data = 2'b11; b_in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_valid got %b want 0000", a_out_valid); end
    n_cmp++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL mid_data got %h want 00", a_out_data); end
    n_cmp++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL mid_err got %b want 0", b_err); end
    n_cmp++; if (b_drop !== 8'd0) begin n_fail++; $display("FAIL mid_drop got %0d want 0", b_drop); end
    n_cmp++; if (b_out_valid !== 3'b000) begin n_fail++; $display("FAIL mid_b_valid got %b want 000", b_out_valid); end
    tick();
    n_cmp++; if (a_out_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_no_word got %b want 0000", a_out_valid); end
    n_cmp++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL mid_no_data got %h want 00", a_out_data); end
  endtask

  initial begin
    test_reset();
    test_route();
    test_stall_pass_through();
    test_parallel_fill();
    test_out_of_range();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_stream_param_module.md
# demux_stream_param_module

Parameterised, registered 1-to-N demultiplexer with valid/ready handshaking. It routes each accepted input word to the output channel named by its select field. Each output channel has a one-entry holding register, so a stalled channel does not block traffic to the other channels. It is the distribution-side counterpart of the mux-on-logic array: the mux merges N lanes into one, and this block fans one stream back out to N lanes.

## Interface
- `WIDTH`, default 2: data width of every lane.
- `N_OUT`, default 4: number of output channels; minimum 2, any value (power of two not required).
- `SEL_W`, default `$clog2(N_OUT)`: select width; derived, do not override.
- `CNT_W`, default 8: width of the drop counter.

Ports (clock and reset first):
- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `in_data`  in  WIDTH  — input word.
- `in_sel`  in  SEL_W  — destination channel index.
- `in_valid`  in  1  — input word/select valid.
- `in_ready`  out  1  — block can accept this cycle.
- `out_data`  out  N_OUT*WIDTH  — channel k occupies `[k*WIDTH +: WIDTH]`.
- `out_valid`  out  N_OUT  — bit k: channel k holds a word.
- `out_ready`  in  N_OUT  — bit k: consumer k takes the word this cycle.
- `err`  out  1  — sticky flag: an out-of-range select was seen.
- `drop_cnt`  out  CNT_W  — number of words dropped for out-of-range select; saturating.

## Operation
- Per-channel state is EMPTY or FULL. `out_valid[k]` is 1 exactly when channel k is FULL.
- Input is accepted when `in_valid && in_ready`.
- `in_ready` is combinational:
  - 1 if `in_sel >= N_OUT`;
  - otherwise 1 if channel `in_sel` is EMPTY, or FULL with `out_ready[in_sel]` = 1 this cycle;
  - it depends on `in_sel` and `out_ready` only, never on `in_valid`.
- On accept with `in_sel = k < N_OUT`: channel k loads `in_data` and becomes FULL.
- Drain: if `out_valid[k] && out_ready[k]`, channel k becomes EMPTY, unless a load to k occurs in the same cycle. In that case it stays FULL with the new word (pass-through, no bubble).
- On accept with `in_sel >= N_OUT`: the word is discarded, `err` is set to 1, and `drop_cnt` increments, saturating at 2^CNT_W − 1.
- Only one channel can be loaded per cycle. Any number of channels can drain in the same cycle.
- While `out_valid[k] && !out_ready[k]`, `out_data` lane k is stable.
- Lane k of `out_data` is held at its last value when EMPTY (no zeroing after drain).
- `err` and `drop_cnt` clear only on `rst`.

## Timing
- Reset: on a `clk` edge with `rst` = 1, all of the following become 0:
  - `out_valid`
  - every `out_data` lane
  - `err`
  - `drop_cnt`

  `in_ready` then follows its combinational rule, so it is 1 with all channels EMPTY.
- Reset mid-operation: held words are lost without being delivered. An input word presented in the reset cycle is not accepted, even though `in_ready` may read 1.
- Latency: a word accepted at edge n appears on `out_valid`/`out_data` right after edge n. It is visible in cycle n+1.
- Throughput: one word per cycle to a single channel if that consumer holds `out_ready` = 1. One word per cycle across alternating channels regardless of back-pressure until their registers fill.
- Back-pressure: if channel k is FULL and `out_ready[k]` = 0, a word for k stalls. It is not dropped, and the upstream source must hold `in_data` and `in_sel` until accepted.
- `err` rises in the cycle after the offending accept.
- `drop_cnt` increments by exactly 1 per offending accept.

## Test plan
- Reset then route, with WIDTH=2 and N_OUT=4: drive `in_sel`=2, `in_data`=2'b11, `in_valid`=1 for one cycle, with `out_ready`=4'b0000.
  - Next cycle: `out_valid`=4'b0100 and lane 2 = 2'b11.
  - `in_ready` for `in_sel`=2 is 0; for `in_sel`=1 it is 1.
- Stall and pass-through: with channel 2 FULL (2'b11) and `out_ready[2]`=0, present 2'b01 to channel 2 for 3 cycles.
  - `in_ready`=0 and lane 2 stays 2'b11.
  - Raise `out_ready[2]`: the same cycle accepts. The next cycle shows lane 2 = 2'b01 with `out_valid[2]` still 1.
- Parallel fill: send 2'b00, 2'b01, 2'b10, 2'b11 to channels 0–3 on consecutive cycles, with `out_ready`=0.
  - Each is accepted with no stall.
  - `out_valid`=4'b1111 and lanes hold 00/01/10/11.
  - Then `out_ready`=4'b1111 for one cycle gives `out_valid`=0.
- Out-of-range select, with N_OUT=3 (SEL_W=2): send `in_sel`=3 twice.
  - Both accepted (`in_ready`=1), `out_valid` unchanged, `err`=1, `drop_cnt`=2.
- Counter saturation, with CNT_W=2 and N_OUT=3: 5 out-of-range accepts give `drop_cnt`=3 and `err`=1.
- Reset mid-operation: with channels 0 and 3 FULL and `err`=1, assert `rst` for one cycle while presenting a valid word.
  - All outputs read 0 afterwards.
  - The presented word does not appear on any channel.
